// File: rtl/weight_tile_streamer_pkg.sv
// Shared types and constants for the weight tile streamer.
//   TILE_DIM      rows per tile and bytes per row (systolic array dimension)
//   weight_row_t  one memory row / one FIFO word: TILE_DIM bytes
//   wts_state_t   streamer FSM states
//   tile_count()  number of 32x32 tiles covering an H x W weight matrix
package weight_tile_streamer_pkg;

    localparam int TILE_DIM = 32;
    localparam int ROW_W    = $clog2(TILE_DIM);
    localparam int DIM_W    = 9;
    // Up to 16 x 16 = 256 tiles; one spare bit keeps "tile index + 1" exact.
    localparam int NT_W     = 10;
    localparam int DRAIN_W  = 2;

    typedef logic [7:0] weight_row_t [TILE_DIM];

    typedef enum logic [2:0] {
        WTS_IDLE,
        WTS_WAIT_REQ,
        WTS_STREAM,
        WTS_DRAIN,
        WTS_DONE
    } wts_state_t;

    // Ceil-divide each dimension by TILE_DIM in 10-bit arithmetic so that
    // 511 + 31 cannot overflow, then multiply (max 16 * 16 = 256).
    function automatic logic [NT_W-1:0] tile_count(input logic [DIM_W-1:0] h,
                                                   input logic [DIM_W-1:0] w);
        logic [NT_W-1:0] th;
        logic [NT_W-1:0] tw;
        th = ({1'b0, h} + NT_W'(TILE_DIM - 1)) >> ROW_W;
        tw = ({1'b0, w} + NT_W'(TILE_DIM - 1)) >> ROW_W;
        return th * tw;
    endfunction

endpackage

// File: rtl/weight_addr_gen.sv
// Tile/row address generator for the weight tile streamer.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-low reset
//   load_i           latch base address and tile count, clear counters
//   adv_row_i        step to the next row of the current tile (wraps at TILE_DIM)
//   next_tile_i      step to the next tile, row counter already back at 0
//   H_DIM_i, W_DIM_i matrix dimensions (used at load and for the zero test)
//   base_addr_i      first memory row of tile 0
//   row_addr_o       base + tile*TILE_DIM + row, modulo 2^ADDR_W
//   nt_zero_o        current H_DIM_i/W_DIM_i describe an empty matrix
//   last_row_o       row counter is on the final row of a tile
//   last_tile_o      tile counter is on the final tile of the matrix
module weight_addr_gen
    import weight_tile_streamer_pkg::*;
#(
    parameter int ADDR_W = 13
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              adv_row_i,
    input  logic              next_tile_i,
    input  logic [DIM_W-1:0]  H_DIM_i,
    input  logic [DIM_W-1:0]  W_DIM_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    output logic [ADDR_W-1:0] row_addr_o,
    output logic              nt_zero_o,
    output logic              last_row_o,
    output logic              last_tile_o
);

    logic [ADDR_W-1:0] tile_base_q;
    logic [NT_W-1:0]   nt_q;
    logic [NT_W-1:0]   tile_q;
    logic [ROW_W-1:0]  row_q;

    // tile_base_q tracks base + tile*TILE_DIM incrementally, so no multiplier
    // is needed; natural ADDR_W overflow gives the required wrap.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tile_base_q <= '0;
            nt_q        <= '0;
            tile_q      <= '0;
            row_q       <= '0;
        end else if (load_i) begin
            tile_base_q <= base_addr_i;
            nt_q        <= tile_count(H_DIM_i, W_DIM_i);
            tile_q      <= '0;
            row_q       <= '0;
        end else if (adv_row_i) begin
            row_q       <= row_q + ROW_W'(1);
        end else if (next_tile_i) begin
            tile_q      <= tile_q + NT_W'(1);
            tile_base_q <= tile_base_q + ADDR_W'(TILE_DIM);
        end
    end

    assign row_addr_o  = tile_base_q + {{(ADDR_W-ROW_W){1'b0}}, row_q};
    assign nt_zero_o   = (H_DIM_i == '0) || (W_DIM_i == '0);
    assign last_row_o  = (row_q == ROW_W'(TILE_DIM - 1));
    assign last_tile_o = ((tile_q + NT_W'(1)) == nt_q);

endmodule

// File: rtl/weight_tile_streamer.sv
// Weight FIFO refill responder: on start_i, streams every tile of the weight
// matrix from weight memory, one full tile per request_data_i handshake.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-low reset
//   start_i               begin a matrix (accepted only in IDLE)
//   H_DIM_i, W_DIM_i      matrix dimensions, sampled at accepted start
//   base_addr_i           memory row of tile 0, sampled at accepted start
//   request_data_i        weight_fifo has room for one full tile
//   mem_rd_en_o           weight memory read strobe
//   mem_addr_o            weight memory row address (0 when not reading)
//   mem_data_i            row data, MEM_LAT cycles after mem_rd_en_o
//   sending_data_o        data_o carries a valid row this cycle
//   data_o                row to weight_fifo, zeros when not sending
//   busy_o                not IDLE
//   done_o                one-cycle pulse after the matrix completes
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start_i
// WAIT_REQ | tiles remain; waiting for request_data_i
// STREAM   | issuing TILE_DIM back-to-back row reads
// DRAIN    | MEM_LAT+1 cycles for the last row to land and request to update
// DONE     | matrix finished; done_o follows one cycle later
module weight_tile_streamer
    import weight_tile_streamer_pkg::*;
#(
    parameter int ADDR_W  = 13,
    parameter int MEM_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DIM_W-1:0]  H_DIM_i,
    input  logic [DIM_W-1:0]  W_DIM_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic              request_data_i,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  weight_row_t       mem_data_i,
    output logic              sending_data_o,
    output weight_row_t       data_o,
    output logic              busy_o,
    output logic              done_o
);

    wts_state_t         state_q, state_d;
    logic [DRAIN_W-1:0] drain_cnt_q;
    logic [MEM_LAT-1:0] rd_pipe_q;
    logic               done_q;

    logic               load, adv_row, next_tile, rd_en;
    logic [ADDR_W-1:0]  row_addr;
    logic               nt_zero, last_row, last_tile;
    logic               drain_end;

    weight_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (load),
        .adv_row_i   (adv_row),
        .next_tile_i (next_tile),
        .H_DIM_i     (H_DIM_i),
        .W_DIM_i     (W_DIM_i),
        .base_addr_i (base_addr_i),
        .row_addr_o  (row_addr),
        .nt_zero_o   (nt_zero),
        .last_row_o  (last_row),
        .last_tile_o (last_tile)
    );

    assign drain_end = (state_q == WTS_DRAIN) && (drain_cnt_q == '0);

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= WTS_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            WTS_IDLE:     if (start_i) state_d = nt_zero ? WTS_DONE : WTS_WAIT_REQ;
            WTS_WAIT_REQ: if (request_data_i) state_d = WTS_STREAM;
            WTS_STREAM:   if (last_row) state_d = WTS_DRAIN;
            WTS_DRAIN:    if (drain_end) state_d = last_tile ? WTS_DONE : WTS_WAIT_REQ;
            WTS_DONE:     state_d = WTS_IDLE;
            default:      state_d = WTS_IDLE;
        endcase
    end

    // Output / strobe logic
    always_comb begin
        load      = 1'b0;
        adv_row   = 1'b0;
        next_tile = 1'b0;
        rd_en     = 1'b0;
        busy_o    = 1'b1;
        case (state_q)
            WTS_IDLE: begin
                busy_o = 1'b0;
                load   = start_i;
            end
            WTS_STREAM: begin
                rd_en   = 1'b1;
                adv_row = 1'b1;
            end
            WTS_DRAIN: next_tile = drain_end && !last_tile;
            default: ;
        endcase
    end

    // Drain down-counter: loaded with MEM_LAT on the last row, so DRAIN
    // lasts MEM_LAT+1 cycles (count MEM_LAT .. 0).
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            drain_cnt_q <= '0;
        end else if (state_q == WTS_STREAM && last_row) begin
            drain_cnt_q <= DRAIN_W'(MEM_LAT);
        end else if (state_q == WTS_DRAIN && drain_cnt_q != '0) begin
            drain_cnt_q <= drain_cnt_q - DRAIN_W'(1);
        end
    end

    // Read-enable delay line: its tail marks the cycle the row is on mem_data_i.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_pipe_q <= '0;
        end else begin
            rd_pipe_q[0] <= rd_en;
            for (int i = 1; i < MEM_LAT; i++) begin
                rd_pipe_q[i] <= rd_pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) done_q <= 1'b0;
        else        done_q <= (state_q == WTS_DONE);
    end

    assign mem_rd_en_o    = rd_en;
    assign mem_addr_o     = rd_en ? row_addr : '0;
    assign sending_data_o = rd_pipe_q[MEM_LAT-1];
    assign done_o         = done_q;

    always_comb begin
        for (int j = 0; j < TILE_DIM; j++) begin
            data_o[j] = sending_data_o ? mem_data_i[j] : 8'h00;
        end
    end

endmodule
